// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package instruction_fetch_pkg;

  localparam int unsigned PC_W       = 64;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = '0;
  localparam logic [INSTR_W-1:0] NOP              = 32'h0;

  // IDLE: no request; WAIT: request outstanding, response kept;
  // DROP: request outstanding, response discarded after a redirect.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} queue between memory responses and the decoder.
module fetch_fifo
  import instruction_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic               o_valid,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [CNT_W-1:0]   o_count
);

  logic [PC_W-1:0]    r_pc    [FIFO_DEPTH];
  logic [INSTR_W-1:0] r_instr [FIFO_DEPTH];
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_pop;

  assign w_pop   = i_pop & o_valid;
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  // Empty queue presents zeros so the decoder sees a NOP at pc 0.
  assign o_pc    = o_valid ? r_pc[r_rd_ptr]    : '0;
  assign o_instr = o_valid ? r_instr[r_rd_ptr] : NOP;

  // Entry storage: write the tail slot on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= NOP;
      end
    end else if (i_push && !i_flush) begin
      r_pc[r_wr_ptr]    <= i_pc;
      r_instr[r_wr_ptr] <= i_instr;
    end
  end

  // Pointers and occupancy; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding memory request, 2-entry prefetch queue,
// branch redirect with flush of queued and in-flight instructions.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] Instruct,
  output logic [PC_W-1:0]    inst_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               Uncondbranch,
  input  logic               Branch,
  input  logic               Zero
);

  fetch_state_e     r_state, w_state_next;
  logic             r_req, w_req_next;
  logic [PC_W-1:0]  r_addr, w_addr_next;
  logic [PC_W-1:0]  r_fetch_pc, w_fetch_pc_next;

  logic             w_consume;
  logic             w_redirect;
  logic [PC_W-1:0]  w_off_b;
  logic [PC_W-1:0]  w_off_cb;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_issue_pc;
  logic             w_push;
  logic             w_flush;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_has_space;

  assign w_consume  = inst_valid & inst_ready;
  assign w_redirect = w_consume & (Uncondbranch | (Branch & ~Zero));
  assign w_off_b    = {{(PC_W-28){Instruct[25]}}, Instruct[25:0], 2'b00};
  assign w_off_cb   = {{(PC_W-21){Instruct[23]}}, Instruct[23:5], 2'b00};
  assign w_target   = inst_pc + (Uncondbranch ? w_off_b : w_off_cb);
  assign w_flush    = w_redirect;
  // Responses are queued only in WAIT and only if not flushed by this redirect.
  assign w_push     = (r_state == S_WAIT) & imem_ack & ~w_redirect;
  assign w_cnt_next = w_flush ? '0 : (w_count + {1'b0, w_push} - {1'b0, w_consume});
  // A new request is allowed only if the queue can still absorb its response.
  assign w_has_space = (w_cnt_next < CNT_W'(FIFO_DEPTH));
  assign w_issue_pc  = w_redirect ? w_target : r_fetch_pc;

  assign imem_req  = r_req;
  assign imem_addr = r_addr;

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pc    (r_addr),
    .i_instr (imem_rdata),
    .i_pop   (w_consume),
    .i_flush (w_flush),
    .o_valid (inst_valid),
    .o_pc    (inst_pc),
    .o_instr (Instruct),
    .o_count (w_count)
  );

  // Request FSM: next state, next request/address and next fetch pc.
  always_comb begin
    w_state_next    = r_state;
    w_req_next      = r_req;
    w_addr_next     = r_addr;
    w_fetch_pc_next = r_fetch_pc;
    unique case (r_state)
      S_IDLE: begin
        if (w_has_space) begin
          w_state_next    = S_WAIT;
          w_req_next      = 1'b1;
          w_addr_next     = w_issue_pc;
          w_fetch_pc_next = w_issue_pc + PC_W'(4);
        end else if (w_redirect) begin
          w_fetch_pc_next = w_target;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (w_has_space) begin
            w_req_next      = 1'b1;
            w_addr_next     = w_issue_pc;
            w_fetch_pc_next = w_issue_pc + PC_W'(4);
          end else begin
            w_state_next = S_IDLE;
            w_req_next   = 1'b0;
          end
        end else if (w_redirect) begin
          // Address must stay put until the ack; remember where to go next.
          w_state_next    = S_DROP;
          w_fetch_pc_next = w_target;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          w_state_next    = S_WAIT;
          w_req_next      = 1'b1;
          w_addr_next     = r_fetch_pc;
          w_fetch_pc_next = r_fetch_pc + PC_W'(4);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_req_next   = 1'b0;
      end
    endcase
  end

  // State, request and pc registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_req      <= w_req_next;
      r_addr     <= w_addr_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench: architectural pc-stream model plus memory responder.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Instruct;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic        Uncondbranch = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;

  instruction_fetch #(.RESET_PC(64'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .Instruct     (Instruct),
    .inst_pc      (inst_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .Uncondbranch (Uncondbranch),
    .Branch       (Branch),
    .Zero         (Zero)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  longint unsigned cyc = 0;
  longint unsigned rel_cyc = 0;
  int mode = 0;          // 0: directed branch program, 1: random
  bit force_stall = 1'b0;
  int cbnz_seen = 0;
  int dly_min = 0;
  int dly_max = 0;

  longint unsigned exp_q [$];
  longint unsigned pc_log [$];
  longint unsigned cyc_log [$];

  // Architectural pc sequence of the directed program (B at 0x10 and 0x24, CBNZ at 0x20).
  longint unsigned exp_seq [14] = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10, 64'h1C, 64'h20,
                                    64'h18, 64'h1C, 64'h20, 64'h24,
                                    64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] x;
    if (a == 64'h10) return 32'h1400_0003;      // B +3 words
    if (a == 64'h20) return 32'hB5FF_FFC0;      // CBNZ imm19 = -2
    if (a == 64'h24) return 32'h17FF_FFF6;      // B -10 words -> wraps below 0
    x = a[31:0] ^ a[63:32];
    x = x * 32'h9E37_79B1;
    return x ^ {x[15:0], x[31:16]};
  endfunction

  function automatic longint unsigned next_pc(input longint unsigned pc, input logic [31:0] w,
                                              input logic ub, input logic br, input logic z);
    logic signed [25:0] i26;
    logic signed [18:0] i19;
    longint s;
    if (ub) begin
      i26 = w[25:0];
      s = i26;
      s = s * 4;
      return pc + longint'(s);
    end else if (br && !z) begin
      i19 = w[23:5];
      s = i19;
      s = s * 4;
      return pc + longint'(s);
    end
    return pc + 64'd4;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: random ack delay per request, data is a function of address.
  bit busy = 1'b0;
  int dcnt = 0;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n || !imem_req) begin
      imem_ack   = 1'b0;
      imem_rdata = '0;
      busy       = 1'b0;
    end else begin
      if (!busy || imem_ack) begin
        busy = 1'b1;
        dcnt = int'($urandom_range(dly_max, dly_min));
      end else begin
        dcnt = dcnt - 1;
      end
      imem_ack   = (dcnt == 0);
      imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end
  end

  // Downstream stimulus: ready and decoded branch flags.
  always begin
    @(posedge clk);
    #1;
    if (mode == 1) begin
      inst_ready   = ($urandom % 4) != 0;
      Uncondbranch = ($urandom % 8) == 0;
      Branch       = ($urandom % 5) == 0;
      Zero         = 1'($urandom % 2);
    end else begin
      inst_ready   = 1'b1;
      Uncondbranch = (inst_pc == 64'h10) || (inst_pc == 64'h24);
      Branch       = (inst_pc == 64'h20);
      Zero         = (cbnz_seen != 0);
    end
    if (force_stall) inst_ready = 1'b0;
  end

  // Monitor: request-hold protocol and consumed-instruction scoreboard.
  bit prev_ok = 1'b0;
  bit prev_req = 1'b0;
  bit prev_ack = 1'b0;
  logic [63:0] prev_addr = '0;
  always @(negedge clk) begin
    longint unsigned e;
    logic [31:0] w;
    if (!rst_n) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok && prev_req && !prev_ack) begin
        n_tests++;
        if (!imem_req || imem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL req_hold got req=%0b addr=%h exp req=1 addr=%h", imem_req, imem_addr, prev_addr);
        end
      end
      prev_ok   = 1'b1;
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      if (inst_valid && inst_ready) begin
        pc_log.push_back(inst_pc);
        cyc_log.push_back(cyc);
        if (inst_pc == 64'h20) cbnz_seen++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL fetch_stream got pc=%h exp none", inst_pc);
        end else begin
          e = exp_q.pop_front();
          w = mem_word(e);
          if (inst_pc !== e || Instruct !== w) begin
            n_fail++;
            $display("FAIL fetch_stream got pc=%h instr=%h exp pc=%h instr=%h", inst_pc, Instruct, e, w);
          end
          exp_q.push_back(next_pc(e, w, Uncondbranch, Branch, Zero));
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", {63'b0, imem_req}, 64'h0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_valid", {63'b0, inst_valid}, 64'h0);
    chk("rst_instr", {32'b0, Instruct}, 64'h0);
    chk("rst_pc", inst_pc, 64'h0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(64'h0);
    pc_log.delete();
    cyc_log.delete();
    cbnz_seen = 0;
    rel_cyc = cyc;
    rst_n = 1'b1;
  endtask

  task automatic wait_consumes(input int n, input int budget);
    int k = 0;
    while (pc_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (pc_log.size() < n) begin
      n_fail++;
      $display("FAIL consume_timeout got %0d exp %0d", pc_log.size(), n);
    end
  endtask

  initial begin
    int n0;
    bit found;
    // Run A: zero-latency memory, directed branches, then a downstream stall.
    mode = 0; dly_min = 0; dly_max = 0;
    #1;
    do_reset();
    @(posedge clk);
    #2;
    chk("first_req", {63'b0, imem_req}, 64'h1);
    chk("first_addr", imem_addr, 64'h0);
    wait_consumes(14, 200);
    for (int i = 0; i < 14 && i < pc_log.size(); i++)
      chk($sformatf("seqA[%0d]", i), pc_log[i], exp_seq[i]);
    if (cyc_log.size() >= 3) begin
      chk("ack_to_valid", cyc_log[0], rel_cyc + 2);
      chk("b2b_1", cyc_log[1], cyc_log[0] + 1);
      chk("b2b_2", cyc_log[2], cyc_log[1] + 1);
    end
    @(posedge clk);
    force_stall = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("stall_req_drop", {63'b0, imem_req}, 64'h0);
    chk("stall_full_valid", {63'b0, inst_valid}, 64'h1);
    force_stall = 1'b0;
    n0 = pc_log.size();
    wait_consumes(n0 + 10, 200);

    // Run B: every ack delayed 3 cycles so redirects land while waiting.
    dly_min = 3; dly_max = 3;
    do_reset();
    wait_consumes(14, 400);
    for (int i = 0; i < 14 && i < pc_log.size(); i++)
      chk($sformatf("seqB[%0d]", i), pc_log[i], exp_seq[i]);

    // Run C: random delays, ready and branch flags, with a reset pulse mid-request.
    mode = 1; dly_min = 0; dly_max = 3;
    do_reset();
    repeat (700) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (imem_req && !imem_ack) found = 1'b1;
    end
    #2;
    do_reset();
    repeat (700) @(negedge clk);
    chk("random_progress", {63'b0, pc_log.size() > 100}, 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
